sha_engine_arb: RTL and testbench
=================================

// Module: sha_engine_arb
// PURPOSE
//  N-channel front-end sharing one SHA engine (engine-side handshake: mode/new_msg/valid/msg -> hash/ready).
//  Round-robin grants the engine to one channel per whole message, forwards its blocks and returns the digest.
//  Adds a per-channel end-of-message marker and a completion pulse that the single-client engine port lacks.
// PARAMETERS
//  N_CH    4                  number of client channels (>=2)
//  MSG_W   $bits(sha::msg_t)  block width
//  HASH_W  $bits(sha::hash_t) digest width
// PORTS
//  clk          in   1             clock
//  rst          in   1             asynchronous, active-high reset
//  ch_valid     in   N_CH          channel i offers a block
//  ch_new_msg   in   N_CH          block is the first of a message
//  ch_last      in   N_CH          block is the last of a message
//  ch_mode      in   N_CH x mode_t requested mode, sampled at grant
//  ch_msg       in   N_CH x MSG_W  block data
//  ch_ready     out  N_CH          block of channel i accepted this cycle
//  ch_done      out  N_CH          1-cycle pulse: hash_o holds channel i digest
//  hash_o       out  HASH_W        last captured digest
//  err_o        out  1             sticky protocol error
//  eng_mode / eng_new_msg / eng_valid / eng_msg   out   engine request side
//  eng_hash     in   HASH_W        engine digest
//  eng_ready    in   1             engine idle / accepting
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, ch_ready=0, ch_done=0, hash_o=0, err_o=0, eng_valid=0, eng_new_msg=0, eng_mode=0.
//  Engine contract: transfer on eng_valid&eng_ready; engine drops ready the cycle after a transfer; ready high again = compression done.
//  FSM IDLE -> BUSY -> WAIT_LO -> WAIT_HI -> IDLE.
//  IDLE: eligible = ch_valid & ch_new_msg. Round-robin from pointer; winner g registered, mode latched, first flag set -> BUSY next cycle.
//   No eligible -> stay. ch_valid without ch_new_msg in IDLE: ignored, no error.
//  BUSY: combinational forward eng_valid=ch_valid[g], eng_msg=ch_msg[g], eng_new_msg=first, eng_mode=latched.
//   ch_ready[g]=eng_ready&ch_valid[g]; all other ch_ready=0. first clears on first transfer.
//   Transfer with ch_last[g] (incl. single-block new_msg&last) -> WAIT_LO.
//   ch_new_msg[g]=1 on a non-first transferred block: err_o<=1, forwarded with eng_new_msg=0.
//   ch_mode[g] changes after grant ignored.
//  WAIT_LO: eng_valid=0; wait eng_ready==0 -> WAIT_HI.
//  WAIT_HI: on eng_ready==1: hash_o<=eng_hash, ch_done[g]=1 next cycle, pointer<=g+1 mod N_CH, -> IDLE.
//   Minimum message overhead: 1 grant cycle + drain; back-to-back messages from the same channel allowed.
//  Simultaneous requests resolved strictly by rr order; a new request never preempts an owner.
//  Reset mid-message: all state cleared immediately; engine shares rst and is also reset; no ch_done issued.
//  hash_o stable between captures.
// STRUCTURE
//  sha package: arb_state_t enum, ch_idx_t = logic [$clog2(N_CH)-1:0], engine contract constants.
//  Sub-module sha_rr_arbiter (req[N_CH], ptr -> one-hot gnt, idx); remainder FSM + muxes in this module.
// TESTING
//  1 Reset: all outputs 0; rst asserted while eng_ready=1 -> no ch_ready.
//  2 Ch1 2-block msg (new_msg, then last), engine latency 3 -> eng_new_msg only on block 0; ch_done=0010; hash_o=eng_hash.
//  3 Ch0,2,3 request same cycle, ptr=0 -> served 0,2,3; then ch0 again after ch3 done.
//  4 Single-block msg (new_msg&last) on ch3 -> WAIT_LO directly; one ch_done[3] pulse.
//  5 Ch2 raises new_msg on block 2 of 3 -> err_o=1 sticky; eng_new_msg stays 0; message completes.
//  6 rst mid-BUSY after 1 of 3 blocks -> IDLE, no ch_done; next new_msg on ch1 served normally.

Source files
------------

// File: rtl/sha_engine_arb_pkg.sv
// Shared types for the SHA engine arbiter: block/digest/mode types, FSM states
// and the engine ready-line levels used by the handshake.
package sha_engine_arb_pkg;

  typedef logic [511:0] msg_t;
  typedef logic [255:0] hash_t;

  typedef enum logic [1:0] {
    MODE_SHA224 = 2'd0,
    MODE_SHA256 = 2'd1,
    MODE_SHA384 = 2'd2,
    MODE_SHA512 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_WAIT_LO,
    ST_WAIT_HI
  } arb_state_t;

  localparam int NUM_CH = 4;
  typedef logic [$clog2(NUM_CH)-1:0] ch_idx_t;

  // Engine ready level: high = idle/accepting, low = compressing.
  localparam logic ENG_IDLE = 1'b1;
  localparam logic ENG_BUSY = 1'b0;

endpackage

// File: rtl/sha_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N_CH.
module sha_rr_arbiter #(
  parameter int N_CH = 4,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int s;
    logic [IDX_W-1:0] c;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    s     = 0;
    c     = '0;
    for (int k = 0; k < N_CH; k++) begin
      s = int'(ptr) + k;
      if (s >= N_CH) s = s - N_CH;
      c = IDX_W'(s);
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/sha_engine_arb.sv
// N-channel front-end sharing one SHA engine: grants the engine to one channel
// per whole message, forwards its blocks, and returns the digest with a done pulse.
module sha_engine_arb
  import sha_engine_arb_pkg::*;
#(
  parameter int N_CH   = NUM_CH,
  parameter int MSG_W  = $bits(msg_t),
  parameter int HASH_W = $bits(hash_t),
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             ch_valid,
  input  logic [N_CH-1:0]             ch_new_msg,
  input  logic [N_CH-1:0]             ch_last,
  input  mode_t [N_CH-1:0]            ch_mode,
  input  logic [N_CH-1:0][MSG_W-1:0]  ch_msg,
  output logic [N_CH-1:0]             ch_ready,
  output logic [N_CH-1:0]             ch_done,
  output logic [HASH_W-1:0]           hash_o,
  output logic                        err_o,
  output mode_t                       eng_mode,
  output logic                        eng_new_msg,
  output logic                        eng_valid,
  output logic [MSG_W-1:0]            eng_msg,
  input  logic [HASH_W-1:0]           eng_hash,
  input  logic                        eng_ready
);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic             first;
  mode_t            mode_q;

  logic [N_CH-1:0]  win_gnt;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             xfer;

  sha_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req (ch_valid & ch_new_msg),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign win_any  = |win_gnt;
  assign eng_mode = mode_q;
  assign xfer     = eng_valid & eng_ready;

  // Only the owning channel sees the engine while a message is in flight.
  always_comb begin
    eng_valid   = 1'b0;
    eng_new_msg = 1'b0;
    eng_msg     = '0;
    ch_ready    = '0;
    if (state == ST_BUSY) begin
      eng_valid       = ch_valid[owner];
      eng_new_msg     = first;
      eng_msg         = ch_msg[owner];
      ch_ready[owner] = eng_ready & ch_valid[owner];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= '0;
      ptr     <= '0;
      first   <= 1'b0;
      mode_q  <= MODE_SHA224;
      hash_o  <= '0;
      ch_done <= '0;
      err_o   <= 1'b0;
    end else begin
      ch_done <= '0;
      unique case (state)
        ST_IDLE: begin
          if (win_any) begin
            owner  <= win_idx;
            mode_q <= ch_mode[win_idx];
            first  <= 1'b1;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (xfer) begin
            first <= 1'b0;
            // A second new_msg inside a granted message is flagged, not restarted.
            if (!first && ch_new_msg[owner]) err_o <= 1'b1;
            if (ch_last[owner]) state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (eng_ready == ENG_BUSY) state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (eng_ready == ENG_IDLE) begin
            hash_o         <= eng_hash;
            ch_done[owner] <= 1'b1;
            ptr            <= (owner == IDX_W'(N_CH - 1)) ? '0 : owner + IDX_W'(1);
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_engine_arb.sv
// Self-checking bench for sha_engine_arb: channel queues drive blocks, a stub
// engine answers the handshake, and a message-level model checks every cycle.
module tb_sha_engine_arb;
  import sha_engine_arb_pkg::*;

  localparam int NC = 4;

  typedef struct {
    msg_t  data;
    logic  nw;
    logic  last;
    mode_t mode;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NC-1:0] ch_valid, ch_new_msg, ch_last, ch_ready, ch_done;
  mode_t [NC-1:0] ch_mode;
  logic [NC-1:0][511:0] ch_msg;
  hash_t hash_o, eng_hash;
  logic  err_o, eng_new_msg, eng_valid, eng_ready;
  mode_t eng_mode;
  msg_t  eng_msg;

  always #5 clk = ~clk;

  sha_engine_arb dut (
    .clk(clk), .rst(rst),
    .ch_valid(ch_valid), .ch_new_msg(ch_new_msg), .ch_last(ch_last),
    .ch_mode(ch_mode), .ch_msg(ch_msg), .ch_ready(ch_ready), .ch_done(ch_done),
    .hash_o(hash_o), .err_o(err_o),
    .eng_mode(eng_mode), .eng_new_msg(eng_new_msg), .eng_valid(eng_valid),
    .eng_msg(eng_msg), .eng_hash(eng_hash), .eng_ready(eng_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  blk_t chq[NC][$];
  int   done_log[$];
  logic [NC-1:0] acc_flag;
  logic [NC-1:0] last_done;
  int   n_acc, n_newx;

  int    ecnt, eng_lat;
  hash_t eacc;
  logic  x_flag, x_new;
  msg_t  x_msg;

  int    m_owner, m_ptr;
  mode_t m_mode;
  hash_t m_digest, m_hash;
  logic  m_err, m_await, m_low, m_due;

  // Toy digest used by the stub engine and by the expected-value model alike.
  function automatic hash_t mix(input hash_t acc, input msg_t b);
    return {acc[254:0], acc[255]} ^ b[255:0] ^ b[511:256];
  endfunction

  function automatic int rr_pick(input int p, input logic [NC-1:0] elig);
    for (int k = 0; k < NC; k++) begin
      int c = (p + k) % NC;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic push(input int ch, input msg_t d, input logic nw, input logic last, input mode_t m);
    blk_t b;
    b.data = d; b.nw = nw; b.last = last; b.mode = m;
    chq[ch].push_back(b);
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      if (chq[i].size() > 0) begin
        ch_valid[i]   = 1'b1;
        ch_new_msg[i] = chq[i][0].nw;
        ch_last[i]    = chq[i][0].last;
        ch_mode[i]    = chq[i][0].mode;
        ch_msg[i]     = chq[i][0].data;
      end else begin
        ch_valid[i]   = 1'b0;
        ch_new_msg[i] = 1'b0;
        ch_last[i]    = 1'b0;
        ch_mode[i]    = MODE_SHA224;
        ch_msg[i]     = '0;
      end
    end
  endtask

  task automatic checkOutput();
    int c;
    int p;
    logic [NC-1:0] exp_done;
    if (rst) begin
      chk(ch_ready == '0, "rst_ch_ready", 512'(ch_ready), 0);
      chk(ch_done == '0, "rst_ch_done", 512'(ch_done), 0);
      chk(hash_o == '0, "rst_hash_o", 512'(hash_o), 0);
      chk(err_o == 1'b0, "rst_err_o", 512'(err_o), 0);
      chk(eng_valid == 1'b0, "rst_eng_valid", 512'(eng_valid), 0);
      chk(eng_new_msg == 1'b0, "rst_eng_new_msg", 512'(eng_new_msg), 0);
      chk(eng_mode == MODE_SHA224, "rst_eng_mode", 512'(eng_mode), 0);
      m_owner = -1; m_ptr = 0; m_err = 1'b0; m_hash = '0;
      m_await = 1'b0; m_low = 1'b0; m_due = 1'b0;
      acc_flag = '0; x_flag = 1'b0;
      return;
    end
    exp_done = '0;
    if (m_due) begin
      exp_done = NC'(1 << m_owner);
      m_hash   = m_digest;
      done_log.push_back(m_owner);
      m_ptr    = (m_owner + 1) % NC;
      m_owner  = -1;
      m_due    = 1'b0;
      m_await  = 1'b0;
    end
    chk(ch_done == exp_done, "ch_done", 512'(ch_done), 512'(exp_done));
    if (ch_done != '0) last_done = ch_done;
    chk(hash_o == m_hash, "hash_o", 512'(hash_o), 512'(m_hash));
    chk(err_o == m_err, "err_o", 512'(err_o), 512'(m_err));

    if (m_owner >= 0 && m_await) begin
      chk(ch_ready == '0, "drain_ch_ready", 512'(ch_ready), 0);
      chk(eng_valid == 1'b0, "drain_eng_valid", 512'(eng_valid), 0);
    end else if (m_owner >= 0) begin
      chk(eng_valid == ch_valid[m_owner], "busy_eng_valid", 512'(eng_valid), 512'(ch_valid[m_owner]));
      chk(ch_ready == ((eng_ready && ch_valid[m_owner]) ? NC'(1 << m_owner) : NC'(0)),
          "busy_ch_ready", 512'(ch_ready), 512'(NC'(1 << m_owner)));
    end else begin
      chk(eng_valid == (ch_ready != '0), "free_eng_valid", 512'(eng_valid), 512'(ch_ready != '0));
    end

    if (eng_valid && eng_ready) begin
      x_flag = 1'b1; x_msg = eng_msg; x_new = eng_new_msg;
      if (eng_new_msg) n_newx++;
    end

    if (ch_ready != '0) begin
      c = 0;
      for (int i = NC - 1; i >= 0; i--) if (ch_ready[i]) c = i;
      chk($onehot(ch_ready), "ready_onehot", 512'(ch_ready), 0);
      chk(eng_msg == ch_msg[c], "eng_msg", eng_msg, ch_msg[c]);
      if (m_owner < 0) begin
        p = rr_pick(m_ptr, ch_valid & ch_new_msg);
        chk(c == p, "rr_grant", 512'(c), 512'(p));
        m_owner  = c;
        m_mode   = ch_mode[c];
        m_digest = mix('0, ch_msg[c]);
        chk(eng_new_msg == 1'b1, "eng_new_msg_first", 512'(eng_new_msg), 1);
      end else begin
        chk(eng_new_msg == 1'b0, "eng_new_msg_mid", 512'(eng_new_msg), 0);
        if (ch_new_msg[c]) m_err = 1'b1;
        m_digest = mix(m_digest, ch_msg[c]);
      end
      chk(eng_mode == m_mode, "eng_mode", 512'(eng_mode), 512'(m_mode));
      acc_flag[c] = 1'b1;
      n_acc++;
      if (ch_last[c]) begin m_await = 1'b1; m_low = 1'b0; end
    end else if (m_await) begin
      if (!eng_ready) m_low = 1'b1;
      else if (m_low) m_due = 1'b1;
    end
  endtask

  // One clock: advance the stub engine and channel queues, then compare.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (!rst) begin
      if (x_flag) begin
        eacc = x_new ? mix('0, x_msg) : mix(eacc, x_msg);
        ecnt = eng_lat;
      end else if (ecnt > 0) begin
        ecnt--;
      end
    end
    x_flag = 1'b0;
    for (int i = 0; i < NC; i++) if (acc_flag[i] && chq[i].size() > 0) chq[i].delete(0);
    acc_flag  = '0;
    eng_ready = (ecnt == 0);
    eng_hash  = eacc;
    drive();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ecnt = 0; eacc = '0; eng_ready = 1'b1; eng_hash = '0;
    for (int i = 0; i < NC; i++) chq[i].delete();
    acc_flag = '0; x_flag = 1'b0;
    drive();
  endtask

  task automatic run_until(input int target, input int budget);
    int k = 0;
    while (done_log.size() < target && k < budget) begin
      applyStimulus();
      k++;
    end
    chk(done_log.size() >= target, "done_wait", 512'(done_log.size()), 512'(target));
  endtask

  initial begin
    int base, n0;
    eng_lat = 3; ecnt = 0; eacc = '0; eng_ready = 1'b1; eng_hash = '0;
    acc_flag = '0; x_flag = 1'b0; x_new = 1'b0; x_msg = '0; last_done = '0;
    n_acc = 0; n_newx = 0;
    m_owner = -1; m_ptr = 0; m_err = 1'b0; m_hash = '0; m_digest = '0;
    m_await = 1'b0; m_low = 1'b0; m_due = 1'b0; m_mode = MODE_SHA224;
    drive();
    #1;
    do_reset();

    // Reset with requests pending and engine ready: nothing may be accepted.
    push(0, 512'h5, 1'b1, 1'b1, MODE_SHA256);
    push(2, 512'h6, 1'b1, 1'b1, MODE_SHA256);
    repeat (4) applyStimulus();
    for (int i = 0; i < NC; i++) chq[i].delete();
    drive();
    rst = 1'b0;
    applyStimulus();

    // Two-block message on ch1, mode change on block 1 must be ignored.
    eng_lat = 3;
    n0 = n_newx;
    push(1, 512'h1, 1'b1, 1'b0, MODE_SHA256);
    push(1, 512'h10, 1'b0, 1'b1, MODE_SHA512);
    run_until(1, 60);
    applyStimulus();
    chk(last_done == 4'b0010, "t2_done_vec", 512'(last_done), 512'(4'b0010));
    chk(hash_o == 256'h12, "t2_hash", 512'(hash_o), 512'h12);
    chk(n_newx - n0 == 1, "t2_new_msg_count", 512'(n_newx - n0), 1);
    chk(eng_mode == MODE_SHA256, "t2_mode_latched", 512'(eng_mode), 512'(MODE_SHA256));

    // Simultaneous requests from ch0, ch2, ch3 with pointer at 0.
    do_reset();
    repeat (2) applyStimulus();
    rst = 1'b0;
    eng_lat = 2;
    base = done_log.size();
    push(0, 512'hA0, 1'b1, 1'b0, MODE_SHA224);
    push(0, 512'hA1, 1'b0, 1'b1, MODE_SHA224);
    push(0, 512'hB0, 1'b1, 1'b1, MODE_SHA384);
    push(2, 512'hC0, 1'b1, 1'b0, MODE_SHA256);
    push(2, 512'hC1, 1'b0, 1'b1, MODE_SHA256);
    push(3, 512'hD0, 1'b1, 1'b0, MODE_SHA512);
    push(3, 512'hD1, 1'b0, 1'b1, MODE_SHA512);
    run_until(base + 4, 200);
    if (done_log.size() >= base + 4) begin
      chk(done_log[base]   == 0, "t3_order0", 512'(done_log[base]), 0);
      chk(done_log[base+1] == 2, "t3_order1", 512'(done_log[base+1]), 2);
      chk(done_log[base+2] == 3, "t3_order2", 512'(done_log[base+2]), 3);
      chk(done_log[base+3] == 0, "t3_order3", 512'(done_log[base+3]), 0);
    end

    // Single-block message on ch3.
    eng_lat = 1;
    base = done_log.size();
    push(3, 512'h3, 1'b1, 1'b1, MODE_SHA384);
    run_until(base + 1, 40);
    applyStimulus();
    chk(last_done == 4'b1000, "t4_done_vec", 512'(last_done), 512'(4'b1000));
    chk(hash_o == 256'h3, "t4_hash", 512'(hash_o), 512'h3);

    // Stray new_msg on block 2 of 3 on ch2: sticky error, message completes.
    eng_lat = 2;
    base = done_log.size();
    push(2, 512'h100, 1'b1, 1'b0, MODE_SHA256);
    push(2, 512'h200, 1'b1, 1'b0, MODE_SHA256);
    push(2, 512'h400, 1'b0, 1'b1, MODE_SHA256);
    run_until(base + 1, 80);
    applyStimulus();
    chk(err_o == 1'b1, "t5_err", 512'(err_o), 1);
    chk(hash_o == 256'h400, "t5_hash", 512'(hash_o), 512'h400);
    repeat (3) applyStimulus();
    chk(err_o == 1'b1, "t5_err_sticky", 512'(err_o), 1);

    // Reset mid-message after one of three blocks, then a clean ch1 message.
    do_reset();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    chk(err_o == 1'b0, "t6_err_cleared", 512'(err_o), 0);
    eng_lat = 3;
    base = done_log.size();
    n0 = n_acc;
    push(2, 512'h7, 1'b1, 1'b0, MODE_SHA256);
    push(2, 512'h8, 1'b0, 1'b0, MODE_SHA256);
    push(2, 512'h9, 1'b0, 1'b1, MODE_SHA256);
    for (int k = 0; k < 20 && n_acc == n0; k++) applyStimulus();
    chk(n_acc > n0, "t6_first_accept", 512'(n_acc - n0), 1);
    applyStimulus();
    do_reset();
    repeat (4) applyStimulus();
    rst = 1'b0;
    repeat (3) applyStimulus();
    chk(done_log.size() == base, "t6_no_done", 512'(done_log.size()), 512'(base));
    push(1, 512'h21, 1'b1, 1'b0, MODE_SHA224);
    push(1, 512'h22, 1'b0, 1'b1, MODE_SHA224);
    run_until(base + 1, 60);
    applyStimulus();
    if (done_log.size() > base)
      chk(done_log[base] == 1, "t6_owner", 512'(done_log[base]), 1);
    chk(last_done == 4'b0010, "t6_done_vec", 512'(last_done), 512'(4'b0010));
    chk(hash_o == 256'h60, "t6_hash", 512'(hash_o), 512'h60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
